// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared constants and state encoding for the program RAM loader
//
// Holds the default RAM geometry so the loader, the RAM and its read path
// agree, plus the loader FSM state type.

package ram_loader_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - MSB-first byte-to-word shift assembler
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clr         : discard any partial word and restart at byte 0
//   in_fire     : a byte transfers this cycle
//   in_byte     : the byte being transferred
//   word_next   : word as it will look once in_byte is shifted in
//   word_done   : in_fire on the last byte of a word

module byte_packer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_fire,
  input  logic [7:0]        in_byte,
  output logic [DATA_W-1:0] word_next,
  output logic              word_done
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Earlier bytes move up one slice per new byte, so the first byte of a
  // word ends up in the top slice.
  assign word_next = (word_q << 8) | DATA_W'(in_byte);
  assign word_done = in_fire && (cnt_q == CW'(NBYTES - 1));

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (in_fire) begin
      word_d = word_next;
      cnt_d  = word_done ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_stream_loader.sv
// rtl/ram_stream_loader.sv - byte-stream front-door loader for the program RAM
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start                  : begin a load (only honoured in IDLE)
//   start_addr, word_count : first address and number of words, captured on start
//   in_valid, in_data      : byte stream in
//   in_ready               : byte accepted this cycle (decoded from state only)
//   ram_cs, ram_we         : one-cycle write strobe per assembled word
//   ram_addr, ram_wdata    : write address/data, held between writes
//   busy                   : load in progress
//   done                   : one-cycle completion pulse

module ram_stream_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              in_fire;
  logic [DATA_W-1:0] word_next;
  logic              word_done;

  assign in_fire = in_valid && in_ready;

  // The packer is held clear whenever the loader is idle, which both
  // starts every load at byte 0 and drops nothing that matters.
  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == ST_IDLE),
    .in_fire   (in_fire),
    .in_byte   (in_data),
    .word_next (word_next),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = start_addr;
          remain_d = word_count;
          state_d  = (word_count != '0) ? ST_RECV : ST_DONE;
        end
      end
      ST_RECV: begin
        // Latch the write port a cycle early so address/data are already
        // registered during WRITE and then simply hold afterwards.
        if (word_done) begin
          waddr_d = addr_q;
          wdata_d = word_next;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d   = addr_q + ADDR_W'(1);
        remain_d = remain_q - (ADDR_W+1)'(1);
        state_d  = (remain_q == (ADDR_W+1)'(1)) ? ST_DONE : ST_RECV;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_WRITE: begin
        ram_cs = 1'b1;
        ram_we = 1'b1;
        busy   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign ram_addr  = waddr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
// tb/tb_ram_stream_loader.sv - scoreboard bench for ram_stream_loader

module tb_ram_stream_loader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              busy;
  logic              done;

  ram_stream_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  exp_done  = 0;
  int  n_vec     = 0;
  int  n_err     = 0;
  int  cyc       = 0;
  int  done_cyc  = 0;
  bit  done_seen = 0;
  bit  saw_ready = 0;
  int  n_writes  = 0;
  int  ram_mem[DEPTH];
  int  model_mem[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the RAM behind the loader plus the write/done scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready) saw_ready = 1;
      if (ram_cs && ram_we) begin
        n_writes++;
        ram_mem[ram_addr] = int'(ram_wdata);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_write: got %0h@%0d expected no write", ram_wdata, ram_addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", int'(ram_addr), e.addr);
          check("wr_data", int'(ram_wdata), e.data);
        end
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        check("busy_at_done", int'(busy), 0);
        if (exp_done == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_done: got done=1 expected 0");
        end else begin
          exp_done--;
        end
      end
    end
  end

  // Reference model: words are bytes taken in order, most significant first,
  // landing at consecutive addresses modulo the RAM depth.
  task automatic model_load(input int sa, input int wc, input int bytes[$], input bit with_done);
    for (int w = 0; w < wc; w++) begin
      wr_t e;
      int  word;
      word = 0;
      for (int k = 0; k < NB; k++) word = word * 256 + bytes[w*NB + k];
      e.addr = (sa + w) % DEPTH;
      e.data = word;
      exp_q.push_back(e);
      model_mem[e.addr] = word;
    end
    if (with_done) exp_done++;
  endtask

  task automatic feed(input int bytes[$], input int stall_pct, input bit mid_start);
    int idx;
    int guard;
    bit fire;
    idx   = 0;
    guard = 0;
    while (idx < bytes.size() && guard < 5000) begin
      in_valid = ($urandom_range(0, 99) >= stall_pct);
      in_data  = bytes[idx][7:0];
      if (mid_start && guard == 3) begin
        start      = 1'b1;
        start_addr = ~start_addr;
        word_count = 3;
      end else begin
        start = 1'b0;
      end
      fire = in_valid && in_ready;
      step();
      if (fire) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < bytes.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL feed_timeout: got %0d bytes expected %0d", idx, bytes.size());
    end
  endtask

  task automatic run_load(input int sa, input int wc, input int bytes[$], input int stall_pct,
                          input bit mid_start, output int lat);
    int c0;
    int g;
    model_load(sa, wc, bytes, 1'b1);
    done_seen  = 0;
    start      = 1'b1;
    start_addr = sa[ADDR_W-1:0];
    word_count = wc[ADDR_W:0];
    c0         = cyc;
    step();
    start = 1'b0;
    feed(bytes, stall_pct, mid_start);
    g = 0;
    while (!done_seen && g < 200) begin
      step();
      g++;
    end
    if (!done_seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done");
      lat = -1;
    end else begin
      lat = done_cyc - c0;
    end
  endtask

  initial begin
    int lat;
    int b[$];
    int nw;
    int sa;
    int wc;

    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i]   = 0;
      model_mem[i] = 0;
    end
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (3) step();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_ram_cs", int'(ram_cs), 0);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_wdata", int'(ram_wdata), 0);
    rst = 1'b0;
    step();

    // Basic load
    b = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_load(0, 2, b, 0, 1'b0, lat);
    check("basic_done_latency", lat, 7);
    check("basic_read0", ram_mem[0], 16'h1234);
    check("basic_read1", ram_mem[1], 16'hABCD);

    // Address wrap
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(31, 2, b, 0, 1'b0, lat);
    check("wrap_read31", ram_mem[31], 16'hDEAD);
    check("wrap_read0", ram_mem[0], 16'hBEEF);

    // Zero count
    b.delete();
    saw_ready = 0;
    nw = n_writes;
    run_load(7, 0, b, 0, 1'b0, lat);
    check("zero_done_latency", lat, 1);
    check("zero_in_ready_seen", int'(saw_ready), 0);
    check("zero_no_write", n_writes, nw);

    // Stalls with a start pulse mid-load, same data as a clean run
    sa = $urandom_range(0, DEPTH - 1);
    b.delete();
    for (int i = 0; i < 4 * NB; i++) b.push_back($urandom_range(0, 255));
    run_load(sa, 4, b, 0, 1'b0, lat);
    check("nostall4_latency", lat, 4 * (NB + 1) + 1);
    run_load(sa, 4, b, 50, 1'b1, lat);

    // Reset in the middle of word 1
    b = '{8'h11, 8'h22, 8'h55};
    model_load(0, 1, '{8'h11, 8'h22}, 1'b0);
    start      = 1'b1;
    start_addr = '0;
    word_count = 2;
    step();
    start = 1'b0;
    feed(b, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    nw = n_writes;
    b = '{8'h66, 8'h77};
    run_load(1, 1, b, 0, 1'b0, lat);
    check("midrst_one_write", n_writes - nw, 1);
    check("midrst_read1", ram_mem[1], 16'h6677);
    check("midrst_read0", ram_mem[0], 16'h1122);

    // Random loads, including counts past the RAM depth
    for (int t = 0; t < 4; t++) begin
      sa = $urandom_range(0, DEPTH - 1);
      wc = (t == 0) ? DEPTH + 5 : $urandom_range(1, 12);
      b.delete();
      for (int i = 0; i < wc * NB; i++) b.push_back($urandom_range(0, 255));
      run_load(sa, wc, b, 30, 1'b0, lat);
    end

    repeat (4) step();
    check("pending_writes", exp_q.size(), 0);
    check("pending_dones", exp_done, 0);
    for (int i = 0; i < DEPTH; i++) check($sformatf("readback_%0d", i), ram_mem[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_stream_loader.md
# ram_stream_loader

Front-door loader for the on-chip 16x32 program RAM. It accepts a byte stream over a valid/ready handshake, assembles bytes MSB-first into RAM words, and writes them through the RAM write port at consecutive addresses. It replaces the simulation-only backdoor `$readmemh` preload, so program memory can be filled from a host interface in both silicon and simulation. It sits between the host byte interface and the RAM, alongside the existing read path (`cs`/`ram_addr`/`read_data`).

## Interface
- `ADDR_W`, 5: RAM address width (32 words).
- `DATA_W`, 16: RAM word width. Must be a multiple of 8; `NBYTES = DATA_W/8`.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: one-cycle request to begin a load; sampled only in IDLE.
- `start_addr` input ADDR_W: first RAM address, captured on an accepted `start`.
- `word_count` input ADDR_W+1: number of words to write, captured on an accepted `start`.
- `in_valid` input 1: byte on `in_data` is valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `ram_cs` output 1: RAM chip select (write strobe qualifier).
- `ram_we` output 1: RAM write enable.
- `ram_addr` output ADDR_W: RAM write address.
- `ram_wdata` output DATA_W: RAM write data.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse when the load completes.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- **IDLE**
  - `in_ready`=0, `busy`=0.
  - `start`=1: capture `start_addr` into the address register and `word_count` into the remaining counter, clear the byte counter.
  - Next state is RECV if `word_count`≠0, otherwise DONE (no RAM write occurs).
- **RECV**
  - `in_ready`=1. A byte transfers only when `in_valid` && `in_ready`.
  - The first byte of a word goes to bits [DATA_W-1:DATA_W-8], the next byte to the following lower slice, and so on (MSB-first).
  - When byte `NBYTES-1` transfers, go to WRITE.
  - `in_valid` low stalls indefinitely with no timeout.
- **WRITE** (exactly one cycle)
  - `ram_cs`=`ram_we`=1, `ram_addr`=current address, `ram_wdata`=assembled word. `in_ready`=0.
  - The address increments modulo 2^ADDR_W, so 31 wraps to 0. The remaining counter decrements.
  - Next state is DONE if the remaining count was 1, otherwise RECV.
- **DONE** (one cycle): `done`=1, `busy`=0, then IDLE.
- `start` outside IDLE is ignored and has no effect on the captured parameters.
- `word_count` > 2^ADDR_W is legal: addresses wrap and earlier words are overwritten.
- `rst` mid-load:
  - Next state is IDLE and the partial word is discarded.
  - Writes already performed remain in the RAM.
  - The host must restart the stream.

## Timing
- Reset values:
  - `in_ready`, `ram_cs`, `ram_we`, `busy`, `done` = 0.
  - `ram_addr`, `ram_wdata` = 0.
  - State = IDLE.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `in_valid` to `in_ready`.
- `start` accepted at cycle N: `busy`=1 and `in_ready`=1 from N+1.
- The last byte of a word accepted at cycle M: write strobe at M+1, `in_ready` back to 1 at M+2.
- With no stalls, each word takes `NBYTES`+1 cycles.
- The final write at cycle W is followed by `done` at W+1 and `busy`=0 at W+1.
- `ram_addr`/`ram_wdata` hold their last values outside WRITE. The RAM must qualify on `ram_cs`&`ram_we`.

## Structure
- A shared package `ram_loader_pkg` holds the state enum and the default `ADDR_W`/`DATA_W` constants, so they match the RAM and its read path.
- One natural sub-module: `byte_packer`, a shift-in byte assembler with a byte counter and a word-complete flag. The FSM, address counter and remaining counter stay in the top module.

## Test plan
- Basic load: `start_addr`=0, `word_count`=2, bytes 12 34 AB CD with no stalls.
  - Writes 0x1234@0, then 0xABCD@1.
  - `done` 7 cycles after `start`.
  - Readback via `ram_addr`/`read_data` returns 1234, ABCD.
- Wrap-around: `start_addr`=31, `word_count`=2, bytes DE AD BE EF.
  - Writes 0xDEAD@31, then 0xBEEF@0.
- Zero count: `word_count`=0.
  - `done` at N+1, no `ram_we` pulse, `in_ready` never high.
- Stalls and ignored start:
  - `in_valid` toggled pseudo-randomly during a 4-word load, with `start` pulsed mid-load.
  - Identical RAM contents to the no-stall case, with the original `start_addr` and `word_count` kept.
- Reset mid-word: `rst` after byte 0x55 of word 1, then a fresh load `start_addr`=1, `word_count`=1, bytes 66 77.
  - Address 1 = 0x6677.
  - Word-0 write kept, no stray write.
